mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   N-port shared-memory arbiter/controller: successor to the two-client IF/MEM
//   controller. Any number of requesters (port 0 = IF, 1 = MEM, more for DMA or
//   debug) share one single-port memory with configurable read latency.
//   Holds losers with per-port wait. Byte-enable writes. Write-protected ROM window.
//   Sits between the core pipeline / bus masters and the RAM/ROM macro.
// PARAMETERS
//   NUM_PORTS    2           number of requesters (1..8)
//   ADDR_W       32          byte address width
//   DATA_W       32          data width; byte enables are DATA_W/8 bits (BE_W)
//   MEM_LATENCY  2           cycles from mem_en to valid mem_rdata (1..15)
//   ROM_BASE     32'h0       first byte of write-protected window
//   ROM_SIZE     32'h1000    window size in bytes; 0 disables protection
// PORTS
//   clk        in   1               clock, all logic on rising edge
//   reset      in   1               synchronous, active-high
//   req        in   NUM_PORTS       per-port request; held high until done
//   we         in   NUM_PORTS*BE_W  per-port byte enables; all-zero = read
//   addr       in   NUM_PORTS*ADDR_W  per-port byte address (word aligned)
//   wdata      in   NUM_PORTS*DATA_W  per-port write data
//   wait_o     out  NUM_PORTS       1 = port must stall, hold req/we/addr/wdata
//   done       out  NUM_PORTS       one-cycle completion pulse
//   rdata      out  DATA_W          read data, valid while any done bit is 1
//   rom_err    out  1               one-cycle pulse: write to ROM window dropped
//   mem_en     out  1               memory access strobe (one cycle)
//   mem_we     out  BE_W            byte write enables to memory
//   mem_addr   out  ADDR_W          memory address
//   mem_wdata  out  DATA_W          memory write data
//   mem_rdata  in   DATA_W          memory read data, valid MEM_LATENCY after mem_en
// BEHAVIOUR
//   - Reset: state IDLE; wait_o, done, rom_err, mem_en, mem_we = 0; rdata,
//     mem_addr, mem_wdata = 0; latency counter 0; rr pointer 0.
//   - wait_o[p] = req[p] & ~done[p] (combinational). An idle port has wait 0.
//   - FSM IDLE: if any req, grant one port (see arbitration); register its
//     we/addr/wdata; assert mem_en for one cycle; go BUSY. With no req, stay.
//   - BUSY: count MEM_LATENCY cycles. Then capture mem_rdata into rdata,
//     pulse done[grant] and go DONE.
//   - DONE: one cycle; done=0; back to IDLE. Next grant is the cycle after that.
//   - Read latency from grant to done = MEM_LATENCY+1 cycles. Writes take the same
//     path and latency. For writes, rdata holds the last value read.
//   - Arbitration (fixed): highest-numbered requesting port wins (MEM beats IF).
//   - ROM guard: write to ROM_BASE <= addr < ROM_BASE+ROM_SIZE goes to memory
//     with mem_we forced to 0 and pulses rom_err with done. Reads are unaffected.
//   - Simultaneous events: a req dropped while granted is illegal (undefined).
//     A new req arriving during BUSY waits. Reset mid-transaction aborts
//     immediately; no done pulse; an in-flight mem_rdata is discarded.
//   - Counter width = $clog2(MEM_LATENCY+1); no wrap, saturates at terminal count.
// CONFIGURATION
//   MEM_ARB_RR_EN defined: round-robin. Search starts at rr_ptr+1 modulo
//     NUM_PORTS; rr_ptr <= granted port on each grant. No port waits more than
//     NUM_PORTS-1 transactions.
//   MEM_ARB_RR_EN undefined: fixed priority as above. rr_ptr not synthesised.
// STRUCTURE
//   mem_arb_pkg: state enum (IDLE/BUSY/DONE), BE_W derivation, ROM-hit function.
//   Sub-module mem_arb_grant: combinational grant selector (fixed/RR by macro),
//     inputs req + rr_ptr, output one-hot grant + encoded index.
// TESTING (mem_arbiter_tb; MEM_LATENCY=2, model RAM preloaded)
//   1 read: port0 req addr 0x2000 (RAM=42), no rivals -> done[0] 3 cycles
//     after grant, rdata=42, wait_o[0]=1 until done.
//   2 contention: ports 0,1 req same cycle -> port1 served first;
//     wait_o[0]=1 throughout; port0 done 4 cycles after port1 done.
//   3 byte write: port1 we=4'b0010 wdata=0xAABBCCDD to 0x2000 (was 0) ->
//     later read returns 0x0000CC00.
//   4 ROM guard: port1 write 0xFFFFFFFF to 0x10 -> rom_err pulse with done;
//     mem_we=0; read 0x10 returns original.
//   5 reset mid-BUSY: assert reset 1 cycle after grant -> no done; all
//     outputs 0 next cycle; a new req is served normally.
//   6 RR (MEM_ARB_RR_EN, NUM_PORTS=3): all ports req continuously ->
//     grant order 1,2,0,1,2,0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned be_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // True when addr lies in [base, base+size); a zero size never hits.
   function automatic logic rom_hit(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] size);
      return (addr >= base) && ((addr - base) < size);
   endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant selector: highest requesting port wins, or round-robin
// after rr_ptr when MEM_ARB_RR_EN is defined.
module mem_arb_grant #(
   parameter int unsigned NUM_PORTS = 2,
   parameter int unsigned IDX_W     = 1
) (
   input  logic [NUM_PORTS-1:0] req,
`ifdef MEM_ARB_RR_EN
   input  logic [IDX_W-1:0]     rr_ptr,
`endif
   output logic [NUM_PORTS-1:0] grant_c,
   output logic [IDX_W-1:0]     grant_idx_c,
   output logic                 any_req_c
);

`ifdef MEM_ARB_RR_EN
   int unsigned best;
   int unsigned dist;

   // Smallest distance past rr_ptr (mod NUM_PORTS) wins.
   always_comb begin
      best        = NUM_PORTS;
      dist        = 0;
      grant_idx_c = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         dist = (i + 2 * NUM_PORTS - 32'(rr_ptr) - 1) % NUM_PORTS;
         if (req[i] && (dist < best)) begin
            best        = dist;
            grant_idx_c = IDX_W'(i);
         end
      end
   end
`else
   always_comb begin
      grant_idx_c = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (req[i]) grant_idx_c = IDX_W'(i);
      end
   end
`endif

   assign any_req_c = |req;
   assign grant_c   = any_req_c ? (NUM_PORTS'(1) << grant_idx_c) : '0;

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter in front of a single-port memory with fixed read latency and a
// write-protected ROM window. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned       NUM_PORTS   = 2,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       MEM_LATENCY = 2,
   parameter logic [ADDR_W-1:0] ROM_BASE    = '0,
   parameter logic [ADDR_W-1:0] ROM_SIZE    = ADDR_W'(32'h1000),
   localparam int unsigned      BE_W        = be_width(DATA_W)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS*BE_W-1:0]     we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   output logic [NUM_PORTS-1:0]          wait_o,
   output logic [NUM_PORTS-1:0]          done,
   output logic [DATA_W-1:0]             rdata,
   output logic                          rom_err,
   output logic                          mem_en,
   output logic [BE_W-1:0]               mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_PORTS-1:0] gnt_q, gnt_d;
   logic                 wr_q, wr_d;
   logic                 rom_q, rom_d;

   logic                 mem_en_d;
   logic [BE_W-1:0]      mem_we_d;
   logic [ADDR_W-1:0]    mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_d;
   logic [DATA_W-1:0]    rdata_d;
   logic [NUM_PORTS-1:0] done_d;
   logic                 rom_err_d;

   logic [NUM_PORTS-1:0] grant_oh;
   logic [IDX_W-1:0]     grant_idx;
   logic                 any_req;

   logic [BE_W-1:0]      we_sel;
   logic [ADDR_W-1:0]    addr_sel;
   logic [DATA_W-1:0]    wdata_sel;
   logic                 wr_sel;
   logic                 rom_wr_sel;

`ifdef MEM_ARB_RR_EN
   logic [IDX_W-1:0]     rr_ptr, rr_ptr_d;
`endif

   mem_arb_grant #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_grant (
      .req         (req),
`ifdef MEM_ARB_RR_EN
      .rr_ptr      (rr_ptr),
`endif
      .grant_c     (grant_oh),
      .grant_idx_c (grant_idx),
      .any_req_c   (any_req)
   );

   // Operand mux for the port about to be granted.
   always_comb begin
      we_sel    = '0;
      addr_sel  = '0;
      wdata_sel = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            we_sel    = we[i*BE_W +: BE_W];
            addr_sel  = addr[i*ADDR_W +: ADDR_W];
            wdata_sel = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign wr_sel     = |we_sel;
   assign rom_wr_sel = wr_sel & rom_hit(64'(addr_sel), 64'(ROM_BASE), 64'(ROM_SIZE));
   assign wait_o     = req & ~done;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      wr_d        = wr_q;
      rom_d       = rom_q;
      mem_en_d    = 1'b0;
      mem_we_d    = '0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      rdata_d     = rdata;
      done_d      = '0;
      rom_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d     = BUSY;
               cnt_d       = CNT_W'(1);
               gnt_d       = grant_oh;
               wr_d        = wr_sel;
               rom_d       = rom_wr_sel;
               mem_en_d    = 1'b1;
               mem_we_d    = rom_wr_sel ? '0 : we_sel;
               mem_addr_d  = addr_sel;
               mem_wdata_d = wdata_sel;
            end
         end
         BUSY: begin
            // Memory data is valid in the cycle the count reaches MEM_LATENCY.
            if (cnt_q == CNT_W'(MEM_LATENCY)) begin
               state_d   = DONE;
               done_d    = gnt_q;
               rom_err_d = rom_q;
               if (!wr_q) rdata_d = mem_rdata;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         gnt_q     <= '0;
         wr_q      <= 1'b0;
         rom_q     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         done      <= '0;
         rom_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         wr_q      <= wr_d;
         rom_q     <= rom_d;
         mem_en    <= mem_en_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         rdata     <= rdata_d;
         done      <= done_d;
         rom_err   <= rom_err_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember the last winner so the search starts just after it.
   always_comb begin
      rr_ptr_d = rr_ptr;
      if ((state_q == IDLE) && any_req) rr_ptr_d = grant_idx;
   end

   always_ff @(posedge clk) begin
      if (reset) rr_ptr <= '0;
      else       rr_ptr <= rr_ptr_d;
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with a model RAM,
// directed scenarios followed by random multi-port traffic.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
   localparam int NP = 3;
`else
   localparam int NP = 2;
`endif
   localparam int LAT = 2;

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } op_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             fill;
   logic [NP-1:0]    req;
   logic [NP*4-1:0]  we;
   logic [NP*32-1:0] addr;
   logic [NP*32-1:0] wdata;
   logic [NP-1:0]    wait_o;
   logic [NP-1:0]    done;
   logic [31:0]      rdata;
   logic             rom_err;
   logic             mem_en;
   logic [3:0]       mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;

   logic [31:0] ram [0:4095];
   logic [31:0] model_ram [0:4095];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   op_t pq [NP][$];
   op_t act_op [NP];
   bit  act [NP];
   int  raise_pct;

   bit          busy;
   int          win, last, grant_cyc, done_cyc, free_cyc;
   op_t         cur_op;
   logic [3:0]  exp_we;
   logic [31:0] exp_rdata, rd_last;
   bit          exp_rom;
   int          order_q[$];
   int          done_at_q[$];

   mem_arbiter #(
      .NUM_PORTS   (NP),
      .ADDR_W      (32),
      .DATA_W      (32),
      .MEM_LATENCY (LAT),
      .ROM_BASE    (32'h0),
      .ROM_SIZE    (32'h1000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .wait_o    (wait_o),
      .done      (done),
      .rdata     (rdata),
      .rom_err   (rom_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 32'h800) return 32'd42;
      if (i == 4)       return 32'h1234_5678;
      return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction

   // Memory with LAT-1 registered stage after the edge that samples mem_en;
   // outside valid cycles the read bus carries junk.
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_word(i);
      end else if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr[13:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      mem_rdata <= mem_en ? ram[mem_addr[13:2]] : $urandom;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NP-1:0] r, input int lst);
`ifdef MEM_ARB_RR_EN
      for (int k = 1; k <= NP; k++) begin
         int p = (lst + k) % NP;
         if (r[p]) return p;
      end
`else
      for (int p = NP - 1; p >= 0; p--) if (r[p]) return p;
`endif
      return 0;
   endfunction

   function automatic bit pending();
      for (int p = 0; p < NP; p++) if (act[p] || pq[p].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   // One cycle: check outputs against the model, retire/raise requests, arbitrate.
   task automatic step();
      logic [NP-1:0] exp_done;
      logic [31:0]   a;
      op_t           op;
      @(negedge clk);
      cyc++;
      exp_done = '0;
      if (busy && cyc == done_cyc) exp_done = NP'(1) << win;
      chk("done", 32'(done), 32'(exp_done));
      chk("rom_err", 32'(rom_err), 32'(exp_done != 0 && exp_rom));
      chk("wait_o", 32'(wait_o), 32'(req & ~exp_done));
      chk("mem_en", 32'(mem_en), 32'(busy && cyc == grant_cyc + 1));
      if (busy && cyc == grant_cyc + 1) begin
         chk("mem_we", 32'(mem_we), 32'(exp_we));
         chk("mem_addr", mem_addr, cur_op.addr);
         chk("mem_wdata", mem_wdata, cur_op.wdata);
      end
      if (exp_done != 0) begin
         chk("rdata", rdata, exp_rdata);
         for (int p = 0; p < NP; p++) if (done[p]) order_q.push_back(p);
         done_at_q.push_back(cyc);
         req      = req & ~exp_done;
         act[win] = 1'b0;
         busy     = 1'b0;
         free_cyc = cyc + 1;
      end
      for (int p = 0; p < NP; p++) begin
         if (!act[p] && pq[p].size() != 0 && $urandom_range(99) < raise_pct) begin
            op = pq[p].pop_front();
            act_op[p]          = op;
            act[p]             = 1'b1;
            we[p*4 +: 4]       = op.we;
            addr[p*32 +: 32]   = op.addr;
            wdata[p*32 +: 32]  = op.wdata;
            req                = req | (NP'(1) << p);
         end
      end
      if (!busy && cyc >= free_cyc && req != 0) begin
         win       = pick(req, last);
         last      = win;
         busy      = 1'b1;
         grant_cyc = cyc;
         done_cyc  = cyc + LAT + 1;
         cur_op    = act_op[win];
         a         = cur_op.addr;
         exp_rom   = (cur_op.we != 0) && (a < 32'h1000);
         exp_we    = exp_rom ? 4'h0 : cur_op.we;
         if (cur_op.we == 0) begin
            exp_rdata = model_ram[a[13:2]];
            rd_last   = exp_rdata;
         end else begin
            exp_rdata = rd_last;
            for (int b = 0; b < 4; b++)
               if (exp_we[b]) model_ram[a[13:2]][b*8 +: 8] = cur_op.wdata[b*8 +: 8];
         end
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      for (int p = 0; p < NP; p++) begin
         act[p] = 1'b0;
         pq[p].delete();
      end
      busy    = 1'b0;
      last    = 0;
      rd_last = '0;
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
      chk("rst_done", 32'(done), 0);
      chk("rst_wait", 32'(wait_o), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rom_err", 32'(rom_err), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      reset    = 1'b0;
      free_cyc = cyc;
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((busy || pending()) && n < budget) begin
         step();
         n++;
      end
      chk("run_timeout", 32'(busy || pending()), 0);
      repeat (2) step();
   endtask

   function automatic op_t mk(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      op_t o;
      o.we = w;
      o.addr = a;
      o.wdata = d;
      return o;
   endfunction

   initial begin
      int n;
      raise_pct = 100;
      for (int i = 0; i < 4096; i++) model_ram[i] = init_word(i);
      fill = 1'b1;
      do_reset(3);
      fill = 1'b0;

      // Single read with no rivals.
      pq[0].push_back(mk(4'h0, 32'h2000, 32'h0));
      run(50);
      chk("t1_rdata", rdata, 32'd42);

      // Two ports request together: port 1 first, port 0 four cycles later.
      order_q.delete();
      done_at_q.delete();
      pq[0].push_back(mk(4'h0, 32'h2000, 32'h0));
      pq[1].push_back(mk(4'h0, 32'h0010, 32'h0));
      run(50);
      chk("t2_count", 32'(order_q.size()), 2);
      chk("t2_first", 32'(order_q[0]), 1);
      chk("t2_second", 32'(order_q[1]), 0);
      chk("t2_gap", 32'(done_at_q[1] - done_at_q[0]), 4);

      // Byte-enable write merges a single byte.
      pq[1].push_back(mk(4'hF, 32'h2000, 32'h0));
      pq[1].push_back(mk(4'b0010, 32'h2000, 32'hAABB_CCDD));
      pq[1].push_back(mk(4'h0, 32'h2000, 32'h0));
      run(100);
      chk("t3_rdata", rdata, 32'h0000_CC00);

      // Write into the ROM window is dropped and flagged.
      pq[1].push_back(mk(4'hF, 32'h0010, 32'hFFFF_FFFF));
      pq[1].push_back(mk(4'h0, 32'h0010, 32'h0));
      run(100);
      chk("t4_rdata", rdata, 32'h1234_5678);

      // Reset one cycle after the grant aborts the transaction.
      pq[0].push_back(mk(4'h0, 32'h2004, 32'h0));
      n = 0;
      while (!busy && n < 10) begin
         step();
         n++;
      end
      chk("t5_granted", 32'(busy), 1);
      step();
      do_reset(1);
      step();
      chk("t5_no_done", 32'(done), 0);
      pq[0].push_back(mk(4'h0, 32'h2004, 32'h0));
      run(50);
      chk("t5_rdata", rdata, init_word(32'h801));

`ifdef MEM_ARB_RR_EN
      // All ports requesting continuously rotate 1,2,0,...
      do_reset(2);
      order_q.delete();
      for (int p = 0; p < NP; p++)
         for (int k = 0; k < 2; k++) pq[p].push_back(mk(4'h0, 32'h2000 + 32'(4 * p), 32'h0));
      run(100);
      begin
         int exp_order [6];
         exp_order = '{1, 2, 0, 1, 2, 0};
         chk("t6_count", 32'(order_q.size()), 6);
         for (int k = 0; k < 6; k++) chk("t6_order", 32'(order_q[k]), 32'(exp_order[k]));
      end
`endif

      // Random traffic from all ports.
      raise_pct = 40;
      for (int p = 0; p < NP; p++) begin
         for (int k = 0; k < 25; k++) begin
            logic [3:0] w;
            case ($urandom_range(3))
               0, 1:    w = 4'h0;
               2:       w = 4'hF;
               default: w = 4'($urandom);
            endcase
            pq[p].push_back(mk(w, 32'($urandom_range(4095)) << 2, $urandom));
         end
      end
      run(20000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
